roulette_spinner: RTL

- Upstream feeder of the roulette game stage. Generates the 5-bit winning number (range 1..31) that the game compares against the player's guess.
- A free-running 5-bit LFSR supplies the entropy. The player's press timing selects where in the sequence the wheel starts.
- A spin FSM animates the wheel for a fixed number of cycles, then latches and holds the result until the game stage acknowledges it.

---
 rtl/roulette_pkg.sv | 18 +
 rtl/roulette_spinner_if.sv | 22 ++
 rtl/roulette_lfsr5.sv | 23 ++
 rtl/roulette_spinner.sv | 114 +++++++++++
 4 files changed

// File: rtl/roulette_pkg.sv
// rtl/roulette_pkg.sv - shared types, widths and LFSR tap function for the roulette spinner
package roulette_pkg;

  localparam int NUM_W = 5;
  localparam logic [NUM_W-1:0] DEFAULT_SEED = 5'b00001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SPIN = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  // x^5 + x^3 + 1, maximal length 31, the all-zero state is unreachable
  function automatic logic [NUM_W-1:0] lfsr5_next(input logic [NUM_W-1:0] q);
    return {q[3:0], q[4] ^ q[2]};
  endfunction

endpackage

// File: rtl/roulette_spinner_if.sv
// rtl/roulette_spinner_if.sv - spin request / result handshake between game stage and spinner
interface roulette_spinner_if;
  import roulette_pkg::*;

  logic             spin_req;
  logic             result_ack;
  logic [NUM_W-1:0] randnum;
  logic             result_valid;
  logic             spinning;
  logic [NUM_W-1:0] spin_display;

  modport master (
    output spin_req, result_ack,
    input  randnum, result_valid, spinning, spin_display
  );

  modport slave (
    input  spin_req, result_ack,
    output randnum, result_valid, spinning, spin_display
  );

endinterface

// File: rtl/roulette_lfsr5.sv
// rtl/roulette_lfsr5.sv - 5-bit Fibonacci LFSR with enable; a zero seed is replaced by 1
module roulette_lfsr5
  import roulette_pkg::*;
#(
  parameter logic [NUM_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic             Clock,
  input  logic             reset_n,
  input  logic             en,
  output logic [NUM_W-1:0] q
);

  localparam logic [NUM_W-1:0] SEED_EFF = (SEED == '0) ? DEFAULT_SEED : SEED;

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= SEED_EFF;
    end else if (en) begin
      q <= lfsr5_next(q);
    end
  end

endmodule

// File: rtl/roulette_spinner.sv
// rtl/roulette_spinner.sv - spin FSM producing a 1..31 winning number from a free-running LFSR
// Optional deceleration near the end of a spin: SPINNER_DECEL_EN
module roulette_spinner
  import roulette_pkg::*;
#(
  parameter int               SPIN_CYCLES = 32,
  parameter logic [NUM_W-1:0] SEED        = DEFAULT_SEED
) (
  input  logic               Clock,
  input  logic               reset_n,
  roulette_spinner_if.slave  bus
);

  localparam logic [7:0] CNT_INIT = 8'(SPIN_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       cnt;
  logic             req_prev;
  logic             spin_edge;
  logic             spin_adv;
  logic             lfsr_en;
  logic             cnt_zero;
  logic [NUM_W-1:0] lfsr_q;
  logic [NUM_W-1:0] lfsr_nx;
  logic [NUM_W-1:0] randnum_r;
  logic             valid_r;

  assign spin_edge = bus.spin_req & ~req_prev;
  assign cnt_zero  = (cnt == 8'd0);
  assign lfsr_nx   = lfsr5_next(lfsr_q);

`ifdef SPINNER_DECEL_EN
  localparam logic [7:0] DECEL_AT = 8'(SPIN_CYCLES / 4);
  // cnt==0 is even, so the final latch always lands on an advance cycle
  assign spin_adv = (cnt >= DECEL_AT) || !cnt[0];
`else
  assign spin_adv = 1'b1;
`endif

  roulette_lfsr5 #(.SEED(SEED)) u_lfsr (
    .Clock   (Clock),
    .reset_n (reset_n),
    .en      (lfsr_en),
    .q       (lfsr_q)
  );

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (spin_edge)      state_nxt = ST_SPIN;
      ST_SPIN: if (cnt_zero)       state_nxt = ST_HOLD;
      ST_HOLD: if (bus.result_ack) state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // The edge-detect cycle does not advance, so the spin starts from the pressed value
  always_comb begin
    bus.spinning = 1'b0;
    lfsr_en      = 1'b0;
    case (state)
      ST_IDLE: lfsr_en = ~spin_edge;
      ST_SPIN: begin
        bus.spinning = 1'b1;
        lfsr_en      = spin_adv;
      end
      default: lfsr_en = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      req_prev  <= 1'b0;
      cnt       <= 8'd0;
      randnum_r <= '0;
      valid_r   <= 1'b0;
    end else begin
      req_prev <= bus.spin_req;
      case (state)
        ST_IDLE: begin
          if (spin_edge) begin
            cnt     <= CNT_INIT;
            valid_r <= 1'b0;
          end
        end
        ST_SPIN: begin
          cnt <= cnt - 8'd1;
          if (cnt_zero) begin
            randnum_r <= lfsr_nx;
            valid_r   <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.result_ack) valid_r <= 1'b0;
        end
        default: valid_r <= 1'b0;
      endcase
    end
  end

  assign bus.randnum      = randnum_r;
  assign bus.result_valid = valid_r;
  assign bus.spin_display = lfsr_q;

endmodule
